// File: rtl/reg_master_pkg.sv
// Shared types for reg_access_master: FSM state encoding and the queued
// command record. Widths here are the default build widths of the master.
package reg_master_pkg;

  localparam int REG_WIDTH_DEF  = 32;
  localparam int ADDR_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic                      wr;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [REG_WIDTH_DEF-1:0]  wdata;
  } reg_cmd_t;

endpackage

// File: rtl/reg_cmd_fifo.sv
// Synchronous command FIFO. The head entry is read straight from the
// storage flops; a pop consumes it and exposes the next entry.
module reg_cmd_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; simultaneous push/pop leaves count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reg_access_master.sv
// Register access initiator: queues host commands, issues one-hot select
// strobes to the register array, captures read data, returns responses.
// Optional macro REG_MASTER_ADDR_CHK_EN flags out-of-range addresses with
// rsp_err and skips the read wait for them.
//
//   state | meaning
//   IDLE  | waiting for a queued command; pops FIFO head when present
//   ISSUE | single-cycle select pulse to the addressed register
//   WAIT  | read latency countdown; captures read slice on terminal count
//   RESP  | response presented, held until rsp_ready
module reg_access_master
  import reg_master_pkg::*;
#(
  parameter int REG_WIDTH  = REG_WIDTH_DEF,
  parameter int REG_NUM    = 8,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_wr,
  input  logic [ADDR_WIDTH-1:0]        cmd_addr,
  input  logic [REG_WIDTH-1:0]         cmd_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_wr,
  output logic [REG_WIDTH-1:0]         rsp_rdata,
  output logic                         rsp_err,
  output logic [REG_NUM-1:0]           reg_wr_sel,
  output logic                         reg_wr_rd,
  output logic [REG_WIDTH-1:0]         reg_wr_data,
  input  logic [REG_NUM*REG_WIDTH-1:0] reg_rd_bus,
  output logic                         busy
);

  localparam logic [2:0]          LAT_LOAD  = 3'(RD_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] REG_NUM_W = (ADDR_WIDTH+1)'(REG_NUM);

  state_t               state_q;
  state_t               state_d;
  reg_cmd_t             cmd_in;
  reg_cmd_t             head;
  reg_cmd_t             cmd_q;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 issue;
  logic                 addr_ok;
  logic [2:0]           lat_cnt_q;
  logic [REG_WIDTH-1:0] rdata_q;
  logic [REG_WIDTH-1:0] rd_slice;

  assign cmd_ready = !fifo_full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && !fifo_empty;
  assign issue     = (state_q == ISSUE);
  assign addr_ok   = ({1'b0, cmd_q.addr} < REG_NUM_W);

  assign cmd_in.wr    = cmd_wr;
  assign cmd_in.addr  = cmd_addr;
  assign cmd_in.wdata = cmd_wdata;

  reg_cmd_fifo #(
    .WIDTH (1 + ADDR_WIDTH + REG_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (cmd_in),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State, command register, latency down-counter and read capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      lat_cnt_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pop) cmd_q <= head;
      if (issue) begin
        lat_cnt_q <= LAT_LOAD;
        rdata_q   <= '0;
      end else if (state_q == WAIT) begin
        if (lat_cnt_q == '0) rdata_q <= rd_slice;
        else                 lat_cnt_q <= lat_cnt_q - 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!fifo_empty) state_d = ISSUE;
`ifdef REG_MASTER_ADDR_CHK_EN
      ISSUE: state_d = (cmd_q.wr || !addr_ok) ? RESP : WAIT;
`else
      ISSUE: state_d = cmd_q.wr ? RESP : WAIT;
`endif
      WAIT:  if (lat_cnt_q == '0) state_d = RESP;
      RESP:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One-hot select decode; an out-of-range address selects nothing.
  always_comb begin
    reg_wr_sel = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (issue && addr_ok && (cmd_q.addr == ADDR_WIDTH'(i))) reg_wr_sel[i] = 1'b1;
    end
  end

  // Read slice mux; out-of-range addresses read as zero.
  always_comb begin
    rd_slice = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (cmd_q.addr == ADDR_WIDTH'(i)) rd_slice = reg_rd_bus[i*REG_WIDTH +: REG_WIDTH];
    end
  end

  assign reg_wr_rd   = issue && cmd_q.wr;
  assign reg_wr_data = (issue && cmd_q.wr) ? cmd_q.wdata : '0;

  assign rsp_valid = (state_q == RESP);
  assign rsp_wr    = rsp_valid && cmd_q.wr;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
`ifdef REG_MASTER_ADDR_CHK_EN
  assign rsp_err   = rsp_valid && !addr_ok;
`else
  assign rsp_err   = 1'b0;
`endif

  assign busy = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_reg_access_master.sv
// Directed bench for reg_access_master with hand-computed expectations.
module tb_reg_access_master;

  localparam int RW = 32;
  localparam int RN = 8;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_wr;
  logic [AW-1:0]   cmd_addr;
  logic [RW-1:0]   cmd_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_wr;
  logic [RW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [RN-1:0]   reg_wr_sel;
  logic            reg_wr_rd;
  logic [RW-1:0]   reg_wr_data;
  logic [RN*RW-1:0] reg_rd_bus;
  logic            busy;

  logic [RW-1:0] bus_val [RN];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int multi_hot = 0;

  typedef struct {
    int          addr;
    logic        wr;
    logic [31:0] data;
    int          cyc;
  } pulse_t;

  pulse_t      pulses[$];
  logic        rsp_wr_log[$];
  logic [31:0] rsp_data_log[$];

  always #5 clk = ~clk;

  reg_access_master dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wr      (cmd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_wr      (rsp_wr),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .reg_wr_sel  (reg_wr_sel),
    .reg_wr_rd   (reg_wr_rd),
    .reg_wr_data (reg_wr_data),
    .reg_rd_bus  (reg_rd_bus),
    .busy        (busy)
  );

  always_comb begin
    reg_rd_bus = '0;
    for (int i = 0; i < RN; i++) reg_rd_bus[i*RW +: RW] = bus_val[i];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Log every select pulse and every response handshake, mid-cycle.
  always @(negedge clk) begin
    pulse_t p;
    if (reg_wr_sel != '0) begin
      p.addr = -1;
      for (int i = 0; i < RN; i++) if (reg_wr_sel[i]) p.addr = i;
      p.wr   = reg_wr_rd;
      p.data = reg_wr_data;
      p.cyc  = cyc;
      pulses.push_back(p);
      if ($countones(reg_wr_sel) > 1) multi_hot++;
    end
    if (rsp_valid && rsp_ready && !rst) begin
      rsp_wr_log.push_back(rsp_wr);
      rsp_data_log.push_back(rsp_rdata);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present a command and hold it until accepted or the bound expires.
  task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [RW-1:0] data,
                      output bit ok);
    ok        = 1'b0;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    #1;
    for (int i = 0; i < 12 && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    bit ok;
    int n, p0, r0, acc;
    bit stable, all_ok;

    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < RN; i++) bus_val[i] = 32'hA0 + i;

    tick(); tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_sel", reg_wr_sel, 0);
    check("rst_wr_rd", reg_wr_rd, 0);
    check("rst_wr_data", reg_wr_data, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_wr", rsp_wr, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", cmd_ready, 1);

    // Write addr 2, data 5.
    send(1'b1, 4'd2, 32'h5, ok);
    check("wr_accept", ok, 1);
    check("wr_c1_sel", reg_wr_sel, 0);
    check("wr_c1_busy", busy, 1);
    tick();
    check("wr_c2_sel", reg_wr_sel, 8'b0000_0100);
    check("wr_c2_rd", reg_wr_rd, 1);
    check("wr_c2_data", reg_wr_data, 32'h5);
    check("wr_c2_rsp_valid", rsp_valid, 0);
    tick();
    check("wr_c3_sel", reg_wr_sel, 0);
    check("wr_c3_data", reg_wr_data, 0);
    check("wr_c3_rsp_valid", rsp_valid, 1);
    check("wr_c3_rsp_wr", rsp_wr, 1);
    check("wr_c3_rsp_err", rsp_err, 0);
    check("wr_c3_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("wr_c4_rsp_valid", rsp_valid, 0);
    check("wr_c4_busy", busy, 0);

    // Read addr 2; slice 2 is valid only in the cycle after the select.
    bus_val[2] = 32'hDEAD_BEEF;
    send(1'b0, 4'd2, 32'h1234_5678, ok);
    check("rd_accept", ok, 1);
    tick();
    check("rd_c2_sel", reg_wr_sel, 8'b0000_0100);
    check("rd_c2_rd", reg_wr_rd, 0);
    check("rd_c2_data", reg_wr_data, 0);
    tick();
    bus_val[2] = 32'h0000_0005;
    check("rd_c3_rsp_valid", rsp_valid, 0);
    tick();
    bus_val[2] = 32'hDEAD_BEEF;
    #1;
    check("rd_c4_rsp_valid", rsp_valid, 1);
    check("rd_c4_rdata", rsp_rdata, 32'h5);
    check("rd_c4_rsp_wr", rsp_wr, 0);
    check("rd_c4_rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Read the highest register.
    p0 = pulses.size();
    send(1'b0, 4'd7, 32'h0, ok);
    wait_rsp(n);
    check("rd7_latency", n, 3);
    check("rd7_rdata", rsp_rdata, 32'hA7);
    check("rd7_sel_addr", (pulses.size() > p0) ? pulses[p0].addr : -1, 7);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Six back-to-back writes with the response channel stalled.
    p0 = pulses.size();
    r0 = rsp_wr_log.size();
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      send(1'b1, AW'(k), 32'h100 + k, ok);
      acc += int'(ok);
    end
    check("b2b_accepted", acc, 5);
    check("b2b_cmd_ready", cmd_ready, 0);
    check("b2b_one_pulse", pulses.size() - p0, 1);
    rsp_ready = 1'b1;
    n = 0;
    while ((rsp_wr_log.size() - r0) < 5 && n < 60) begin
      tick();
      n++;
    end
    check("b2b_rsp_count", rsp_wr_log.size() - r0, 5);
    check("b2b_pulse_count", pulses.size() - p0, 5);
    all_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (p0 + i < pulses.size()) begin
        if (pulses[p0+i].addr != i || pulses[p0+i].data != 32'h100 + i || !pulses[p0+i].wr)
          all_ok = 1'b0;
      end else all_ok = 1'b0;
      if (r0 + i < rsp_wr_log.size()) begin
        if (rsp_wr_log[r0+i] !== 1'b1 || rsp_data_log[r0+i] !== 32'h0) all_ok = 1'b0;
      end else all_ok = 1'b0;
    end
    check("b2b_order", all_ok, 1);
    check("b2b_spacing",
          (pulses.size() >= p0 + 3) ? pulses[p0+2].cyc - pulses[p0+1].cyc : -1, 3);
    tick();
    check("b2b_drained_busy", busy, 0);
    rsp_ready = 1'b0;

    // Read response held for 10 stalled cycles.
    bus_val[5] = 32'hCAFE_0005;
    send(1'b0, 4'd5, 32'h0, ok);
    wait_rsp(n);
    check("hold_rsp_valid", rsp_valid, 1);
    p0 = pulses.size();
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus_val[5] = $urandom;
      tick();
      if (!(rsp_valid === 1'b1 && rsp_rdata === 32'hCAFE_0005 && rsp_wr === 1'b0 &&
            rsp_err === 1'b0)) stable = 1'b0;
    end
    check("hold_stable", stable, 1);
    check("hold_no_pulse", pulses.size() - p0, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("hold_released", rsp_valid, 0);

    // Out-of-range read.
    p0 = pulses.size();
    send(1'b0, 4'd9, 32'h0, ok);
    wait_rsp(n);
`ifdef REG_MASTER_ADDR_CHK_EN
    check("oor_latency", n, 2);
    check("oor_err", rsp_err, 1);
`else
    check("oor_latency", n, 3);
    check("oor_err", rsp_err, 0);
`endif
    check("oor_rdata", rsp_rdata, 0);
    check("oor_no_sel", pulses.size() - p0, 0);
    rsp_ready = 1'b1;
    tick();

    // Reset while a read is waiting and two writes are queued.
    p0 = pulses.size();
    r0 = rsp_wr_log.size();
    send(1'b0, 4'd3, 32'h0, ok);
    send(1'b1, 4'd4, 32'h44, ok);
    send(1'b1, 4'd6, 32'h66, ok);
    check("rstw_busy", busy, 1);
    check("rstw_rsp_valid", rsp_valid, 0);
    rst = 1'b1;
    tick();
    check("rstw_sel", reg_wr_sel, 0);
    check("rstw_wr_rd", reg_wr_rd, 0);
    check("rstw_wr_data", reg_wr_data, 0);
    check("rstw_rsp_valid_after", rsp_valid, 0);
    check("rstw_rsp_rdata", rsp_rdata, 0);
    check("rstw_rsp_wr", rsp_wr, 0);
    check("rstw_rsp_err", rsp_err, 0);
    check("rstw_busy_after", busy, 0);
    check("rstw_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("rstw_no_rsp", rsp_wr_log.size() - r0, 0);
    check("rstw_one_pulse", pulses.size() - p0, 1);
    check("rstw_idle", busy, 0);

    check("one_hot", multi_hot, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_access_master.md
# reg_access_master

Bus-side initiator for the register field blocks: accepts register read/write commands over a valid/ready interface and queues them in a small command FIFO. It drives the one-hot `reg_wr_sel` / `reg_wr_rd` / `reg_wr_data` strobes that the register modules respond to, and captures their `reg_rd_out` data. It then returns one response per command over a valid/ready response channel. It sits between the host/test driver and an array of up to REG_NUM register instances.

## Interface
- REG_WIDTH, 32, register data width
- REG_NUM, 8, number of attached registers (one select bit each)
- ADDR_WIDTH, 4, command address width; must be ≥ clog2(REG_NUM)
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥ 2
- RD_LATENCY, 1, cycles from select to valid `reg_rd_out` data; range 1..4
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_wr  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  register index
- cmd_wdata  in  REG_WIDTH  write data
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_wr  out  1  echo of the command type
- rsp_rdata  out  REG_WIDTH  read data; 0 for writes
- rsp_err  out  1  address error (see Configuration)
- reg_wr_sel  out  REG_NUM  one-hot register select
- reg_wr_rd  out  1  1 = write, 0 = read
- reg_wr_data  out  REG_WIDTH  write data to registers
- reg_rd_bus  in  REG_NUM*REG_WIDTH  concatenated `reg_rd_out` of all registers; slice i = register i
- busy  out  1  FSM not IDLE or FIFO not empty

## Operation
- Command accepted when `cmd_valid && cmd_ready`. `cmd_ready = !fifo_full && !rst`.
- FSM states:
  - IDLE: if FIFO not empty, pop the head into the command register, then go to ISSUE.
  - ISSUE: one cycle. Drive `reg_wr_sel[addr]=1`, `reg_wr_rd=cmd_wr`, `reg_wr_data=cmd_wdata` (wdata = 0 for reads). Writes go to RESP. Reads go to WAIT.
  - WAIT: count RD_LATENCY cycles. On the last one, capture slice `addr` of `reg_rd_bus` into `rsp_rdata`, then go to RESP.
  - RESP: `rsp_valid=1` and all rsp_* held stable until `rsp_ready`. On the handshake, go to IDLE.
- Outside ISSUE: `reg_wr_sel=0`, `reg_wr_rd=0`, `reg_wr_data=0`.
- Exactly one select pulse per command; never more than one bit of `reg_wr_sel` high.
- Strict in-order: responses are returned in command order, and there is one outstanding register access at a time.
- FIFO push and pop in the same cycle: occupancy is unchanged.
- A command arriving while `cmd_ready=0` is not accepted; the source must hold it.

## Timing
- Reset values: `cmd_ready=0` while rst is high, 1 on the first cycle after. All other outputs are 0. FIFO is empty and the FSM is in IDLE.
- Command accepted in cycle C with the FIFO empty and the FSM idle:
  - Pop occurs in C+1.
  - ISSUE (select pulse) occurs in C+2.
  - Write response: `rsp_valid` in C+3.
  - Read: data is sampled at the end of C+2+RD_LATENCY, and `rsp_valid` is asserted in C+3+RD_LATENCY.
- One IDLE bubble between the response handshake and the next pop. Write throughput is 1 per 3 cycles with `rsp_ready=1`.
- Reset mid-operation: at the first clk edge with rst high, the in-flight command and the FIFO contents are dropped. Every output takes its reset value and no response is produced.

## Configuration
- `REG_MASTER_ADDR_CHK_EN` defined: an address ≥ REG_NUM still takes the ISSUE cycle, but with `reg_wr_sel=0`. It then goes straight to RESP with `rsp_err=1` and `rsp_rdata=0`, giving write latency for both types.
- Undefined: `rsp_err` is tied 0. An out-of-range address produces `reg_wr_sel=0` and `rsp_rdata=0`, with the normal read/write latency.

## Structure
- Package `reg_master_pkg` holds the FSM state enum (IDLE, ISSUE, WAIT, RESP) and the command struct typedef (wr, addr, wdata).
- Sub-module `reg_cmd_fifo`: synchronous FIFO, width 1+ADDR_WIDTH+REG_WIDTH, depth FIFO_DEPTH. Outputs full, empty, and the head entry (registered head, pop-to-consume).
- The top level contains the FSM, the RD_LATENCY counter, the select decoder and the read-slice mux.

## Test plan
- Write addr 2, data 0x5, accepted at C → `reg_wr_sel=8'b0000_0100`, `reg_wr_rd=1`, `reg_wr_data=0x5` for exactly cycle C+2; `rsp_valid` at C+3 with `rsp_wr=1`, `rsp_err=0`.
- Read addr 2, with the bench driving slice 2 = 0x0000_0005 one cycle after select → `rsp_rdata=0x5`, `rsp_wr=0`, `rsp_valid` at C+4.
- With `rsp_ready=0`, issue 6 back-to-back writes → 5 are accepted (1 in the FSM, 4 in the FIFO) and `cmd_ready` drops. Only 1 select pulse occurs until `rsp_ready` rises. All 5 responses then arrive in order.
- Hold `rsp_ready=0` for 10 cycles during a read response → rsp_* stay stable and no select pulse occurs.
- Read addr 9 → with the macro: no select bit, `rsp_err=1`, `rsp_rdata=0` at C+3. Without the macro: `rsp_err=0`, `rsp_rdata=0` at C+4.
- Assert rst for one cycle during WAIT → next cycle all outputs are 0, `busy=0`, and no response is ever produced for the dropped commands.
